// File: rtl/code_entry.sv
// ----------------------------------------------------------------------------
// code_entry
// Keypad digit capture and code comparison stage that feeds the lock
// controller. Collects digits into an entry buffer while read_input is high,
// holds the stored user code (uc), and reports length/match status for the
// comparison type selected by compareType.
//
// Ports:
//   hwclk          system clock
//   reset          synchronous, active-high reset
//   button[3:0]    keypad value, valid while bstate is high
//   bstate         key-held level; a release (1->0) is a press event
//   read_input     entry window from the controller
//   compareType    00 COMPAREPC, 01 COMPAREUC, 10 MATCHUC, 11 STOREUC
//   store          rising edge commits the candidate as the user code
//   correct_input  comparison result (combinational from registers)
//   data_ready     registered ~read_input
//   validLength    entry length within user-code limits
//   validLengthPC  entry length equals the program-code length
//
// Optional feature: define CODE_LOCKOUT_EN to add a failed-attempt counter
// that locks out comparisons and digit entry for LOCKOUT_CYCLES cycles after
// three consecutive failed COMPAREUC attempts.
// ----------------------------------------------------------------------------
module code_entry #(
    parameter int unsigned                   MAX_LEN        = 8,
    parameter int unsigned                   MIN_LEN        = 4,
    parameter int unsigned                   PC_LEN         = 6,
    parameter logic [4*PC_LEN-1:0]           PC_VALUE       = 24'h123456,
    parameter int unsigned                   UC_DEFAULT_LEN = 4,
    parameter logic [4*UC_DEFAULT_LEN-1:0]   UC_DEFAULT     = 16'h1234,
    parameter int unsigned                   LOCKOUT_CYCLES = 12_000_000
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] button,
    input  logic       bstate,
    input  logic       read_input,
    input  logic [1:0] compareType,
    input  logic       store,
    output logic       correct_input,
    output logic       data_ready,
    output logic       validLength,
    output logic       validLengthPC
);

    localparam int unsigned EW = 4 * MAX_LEN;
    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] T_COMPAREPC = 2'b00;
    localparam logic [1:0] T_COMPAREUC = 2'b01;
    localparam logic [1:0] T_MATCHUC   = 2'b10;
    localparam logic [1:0] T_STOREUC   = 2'b11;

    localparam logic [EW-1:0] PC_EXT = EW'(PC_VALUE);
    localparam logic [EW-1:0] UC_EXT = EW'(UC_DEFAULT);

    logic [EW-1:0] entry;
    logic [CW-1:0] count;
    logic          ovf;
    logic [EW-1:0] cand;
    logic [CW-1:0] cand_len;
    logic [EW-1:0] uc;
    logic [CW-1:0] uc_len;
    logic [3:0]    btn_q;
    logic          prev_bstate;
    logic          prev_read;
    logic [1:0]    prev_type;
    logic          prev_store;

    logic press;
    logic is_digit;
    logic rd_rise;
    logic type_chg;
    logic clear;
    logic take_digit;
    logic store_rise;
    logic pc_match;
    logic uc_match;
    logic cand_match;
    logic locked;

    // Event decode
    assign press      = prev_bstate & ~bstate;
    assign is_digit   = (btn_q <= 4'd6);
    assign rd_rise    = read_input & ~prev_read;
    assign type_chg   = read_input & (compareType != prev_type);
    assign clear      = rd_rise | type_chg;
    assign take_digit = press & is_digit & read_input & ~locked;
    assign store_rise = store & ~prev_store;

    // Comparisons against the three reference codes
    assign pc_match   = (entry == PC_EXT) && (count == CW'(PC_LEN));
    assign uc_match   = (entry == uc)     && (count == uc_len);
    assign cand_match = (entry == cand)   && (count == cand_len);

    assign validLength   = ~ovf & (count >= CW'(MIN_LEN)) & (count <= CW'(MAX_LEN));
    assign validLengthPC = ~ovf & (count == CW'(PC_LEN));

    // Result is only meaningful once the entry window has closed
    always_comb begin
        correct_input = 1'b0;
        if (!read_input && !locked) begin
            case (compareType)
                T_COMPAREPC: correct_input = pc_match;
                T_COMPAREUC: correct_input = uc_match;
                T_MATCHUC:   correct_input = cand_match;
                T_STOREUC:   correct_input = 1'b0;
                default:     correct_input = 1'b0;
            endcase
        end
    end

    // Entry buffer, candidate/user code storage and edge-detect history
    always_ff @(posedge hwclk) begin
        if (reset) begin
            entry       <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            cand        <= '0;
            cand_len    <= '0;
            uc          <= UC_EXT;
            uc_len      <= CW'(UC_DEFAULT_LEN);
            btn_q       <= 4'd0;
            prev_bstate <= 1'b0;
            prev_read   <= 1'b0;
            prev_type   <= T_COMPAREPC;
            prev_store  <= 1'b0;
            data_ready  <= 1'b0;
        end else begin
            prev_bstate <= bstate;
            btn_q       <= button;
            prev_read   <= read_input;
            prev_type   <= compareType;
            prev_store  <= store;
            data_ready  <= ~read_input;

            // Clear wins over a coincident press; leaving STOREUC snapshots the entry
            if (clear) begin
                if (type_chg && (prev_type == T_STOREUC)) begin
                    cand     <= entry;
                    cand_len <= count;
                end
                entry <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if (take_digit) begin
                if (count < CW'(MAX_LEN)) begin
                    entry <= {entry[EW-5:0], btn_q};
                    count <= count + CW'(1);
                end else begin
                    ovf <= 1'b1;
                end
            end

            // Nonblocking read of cand: a coincident snapshot is seen next edge
            if (store_rise) begin
                uc     <= cand;
                uc_len <= cand_len;
            end
        end
    end

`ifdef CODE_LOCKOUT_EN
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

    logic [1:0]    fail_cnt;
    logic [LW-1:0] lock_cnt;
    logic          attempt;

    // data_ready rises exactly one cycle after read_input falls; keying on the
    // falling window edge avoids counting the idle data_ready rise after reset
    assign attempt = prev_read & ~read_input & (compareType == T_COMPAREUC) & ~locked;

    // Consecutive-failure counter and lockout timer
    always_ff @(posedge hwclk) begin
        if (reset) begin
            fail_cnt <= 2'd0;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (locked) begin
            if (lock_cnt == LW'(1)) begin
                locked <= 1'b0;
            end
            lock_cnt <= lock_cnt - LW'(1);
        end else if (attempt) begin
            if (uc_match) begin
                fail_cnt <= 2'd0;
            end else if (fail_cnt == 2'd2) begin
                fail_cnt <= 2'd0;
                locked   <= 1'b1;
                lock_cnt <= LW'(LOCKOUT_CYCLES);
            end else begin
                fail_cnt <= fail_cnt + 2'd1;
            end
        end
    end
`else
    logic unused_lockout;

    assign locked         = 1'b0;
    assign unused_lockout = ^32'(LOCKOUT_CYCLES);
`endif

endmodule

// File: tb/tb_code_entry.sv
module tb_code_entry;

    logic       hwclk;
    logic       reset;
    logic [3:0] button;
    logic       bstate;
    logic       read_input;
    logic [1:0] compareType;
    logic       store;
    logic       correct_input;
    logic       data_ready;
    logic       validLength;
    logic       validLengthPC;

    int total_cnt;
    int pass_cnt;

    code_entry dut (
        .hwclk         (hwclk),
        .reset         (reset),
        .button        (button),
        .bstate        (bstate),
        .read_input    (read_input),
        .compareType   (compareType),
        .store         (store),
        .correct_input (correct_input),
        .data_ready    (data_ready),
        .validLength   (validLength),
        .validLengthPC (validLengthPC)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    // Key held one cycle, then released; event registers on the second edge
    task automatic press(input logic [3:0] d);
        button = d;
        bstate = 1'b1;
        tick();
        bstate = 1'b0;
        tick();
    endtask

    task automatic open_win(input logic [1:0] t);
        compareType = t;
        read_input  = 1'b1;
        tick();
    endtask

    task automatic close_win();
        read_input = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; button = 4'd0; bstate = 1'b0; read_input = 1'b0;
        compareType = 2'b00; store = 1'b0;
        tick(); tick();
        total_cnt++; if (correct_input !== 1'b0) $display("FAIL rst_correct: got %b want 0", correct_input); else pass_cnt++;
        total_cnt++; if (data_ready !== 1'b0) $display("FAIL rst_data_ready: got %b want 0", data_ready); else pass_cnt++;
        total_cnt++; if (validLength !== 1'b0) $display("FAIL rst_vlen: got %b want 0", validLength); else pass_cnt++;
        total_cnt++; if (validLengthPC !== 1'b0) $display("FAIL rst_vlenpc: got %b want 0", validLengthPC); else pass_cnt++;
        total_cnt++; if (dut.uc !== 32'h1234) $display("FAIL rst_uc: got %h want 00001234", dut.uc); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_compare_uc();
        open_win(2'b01);
        press(4'd1); press(4'd2); press(4'd3);
        total_cnt++; if (validLength !== 1'b0) $display("FAIL uc_vlen3: got %b want 0", validLength); else pass_cnt++;
        press(4'd4);
        total_cnt++; if (validLength !== 1'b1) $display("FAIL uc_vlen4: got %b want 1", validLength); else pass_cnt++;
        total_cnt++; if (correct_input !== 1'b0) $display("FAIL uc_correct_open: got %b want 0", correct_input); else pass_cnt++;
        close_win();
        total_cnt++; if (correct_input !== 1'b1) $display("FAIL uc_correct: got %b want 1", correct_input); else pass_cnt++;
        total_cnt++; if (data_ready !== 1'b0) $display("FAIL uc_ready_early: got %b want 0", data_ready); else pass_cnt++;
        tick();
        total_cnt++; if (data_ready !== 1'b1) $display("FAIL uc_ready: got %b want 1", data_ready); else pass_cnt++;
    endtask

    task automatic test_compare_pc();
        open_win(2'b00);
        for (int i = 1; i <= 6; i++) press(4'(i));
        total_cnt++; if (validLengthPC !== 1'b1) $display("FAIL pc_vlenpc6: got %b want 1", validLengthPC); else pass_cnt++;
        close_win();
        total_cnt++; if (correct_input !== 1'b1) $display("FAIL pc_correct6: got %b want 1", correct_input); else pass_cnt++;
        press(4'd1);
        total_cnt++; if (dut.count !== 4'd6) $display("FAIL pc_closed_press: got %0d want 6", dut.count); else pass_cnt++;
        total_cnt++; if (correct_input !== 1'b1) $display("FAIL pc_closed_correct: got %b want 1", correct_input); else pass_cnt++;
        open_win(2'b00);
        for (int i = 1; i <= 5; i++) press(4'(i));
        total_cnt++; if (validLengthPC !== 1'b0) $display("FAIL pc_vlenpc5: got %b want 0", validLengthPC); else pass_cnt++;
        close_win();
        total_cnt++; if (correct_input !== 1'b0) $display("FAIL pc_correct5: got %b want 0", correct_input); else pass_cnt++;
        tick();
    endtask

    task automatic test_overflow();
        open_win(2'b01);
        for (int i = 1; i <= 8; i++) press(4'(i % 7));
        total_cnt++; if (validLength !== 1'b1) $display("FAIL ovf_vlen8: got %b want 1", validLength); else pass_cnt++;
        press(4'd1);
        total_cnt++; if (dut.count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", dut.count); else pass_cnt++;
        total_cnt++; if (dut.ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", dut.ovf); else pass_cnt++;
        total_cnt++; if (validLength !== 1'b0) $display("FAIL ovf_vlen: got %b want 0", validLength); else pass_cnt++;
        close_win();
        tick();
        open_win(2'b01);
        press(4'd1); press(4'd2);
        press(4'd7); press(4'd8); press(4'd9);
        total_cnt++; if (dut.count !== 4'd2) $display("FAIL cmd_count: got %0d want 2", dut.count); else pass_cnt++;
        press(4'd3);
        total_cnt++; if (dut.entry !== 32'h0000_0123) $display("FAIL cmd_entry: got %h want 00000123", dut.entry); else pass_cnt++;
        close_win();
        tick();
    endtask

    task automatic test_clear_wins();
        open_win(2'b01);
        press(4'd1); press(4'd2);
        button = 4'd3; bstate = 1'b1;
        tick();
        bstate = 1'b0; compareType = 2'b00;
        tick();
        total_cnt++; if (dut.count !== 4'd0) $display("FAIL clr_wins_count: got %0d want 0", dut.count); else pass_cnt++;
        close_win();
        tick();
    endtask

    task automatic test_store_flow();
        open_win(2'b11);
        for (int i = 0; i < 4; i++) press(4'd5);
        total_cnt++; if (correct_input !== 1'b0) $display("FAIL st_correct_storeuc: got %b want 0", correct_input); else pass_cnt++;
        compareType = 2'b10;
        tick();
        total_cnt++; if (dut.cand !== 32'h5555) $display("FAIL st_cand: got %h want 00005555", dut.cand); else pass_cnt++;
        total_cnt++; if (dut.count !== 4'd0) $display("FAIL st_clear: got %0d want 0", dut.count); else pass_cnt++;
        for (int i = 0; i < 4; i++) press(4'd5);
        close_win();
        total_cnt++; if (correct_input !== 1'b1) $display("FAIL st_matchuc: got %b want 1", correct_input); else pass_cnt++;
        store = 1'b1;
        repeat (10) tick();
        store = 1'b0;
        tick();
        total_cnt++; if (dut.uc !== 32'h5555) $display("FAIL st_uc: got %h want 00005555", dut.uc); else pass_cnt++;
        open_win(2'b01);
        for (int i = 0; i < 4; i++) press(4'd5);
        close_win();
        total_cnt++; if (correct_input !== 1'b1) $display("FAIL st_new_uc: got %b want 1", correct_input); else pass_cnt++;
        tick();
        open_win(2'b01);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        close_win();
        total_cnt++; if (correct_input !== 1'b0) $display("FAIL st_old_uc: got %b want 0", correct_input); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        open_win(2'b01);
        press(4'd1); press(4'd2); press(4'd3);
        total_cnt++; if (dut.count !== 4'd3) $display("FAIL rm_count3: got %0d want 3", dut.count); else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++; if (dut.count !== 4'd0) $display("FAIL rm_count: got %0d want 0", dut.count); else pass_cnt++;
        total_cnt++; if (data_ready !== 1'b0) $display("FAIL rm_ready: got %b want 0", data_ready); else pass_cnt++;
        total_cnt++; if (dut.uc !== 32'h1234) $display("FAIL rm_uc: got %h want 00001234", dut.uc); else pass_cnt++;
        store = 1'b1;
        tick();
        total_cnt++; if (dut.uc !== 32'h1234) $display("FAIL rm_store_uc: got %h want 00001234", dut.uc); else pass_cnt++;
        total_cnt++; if (validLength !== 1'b0) $display("FAIL rm_vlen: got %b want 0", validLength); else pass_cnt++;
        reset = 1'b0; store = 1'b0; read_input = 1'b0;
        tick();
        open_win(2'b01);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        close_win();
        total_cnt++; if (correct_input !== 1'b1) $display("FAIL rm_default_uc: got %b want 1", correct_input); else pass_cnt++;
        tick();
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        test_reset();
        test_compare_uc();
        test_compare_pc();
        test_overflow();
        test_clear_wins();
        test_store_flow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
